// File: rtl/ula_pkg.sv
// Shared ALU opcode definitions and the multiply/divide unit's state encoding.
package ula_pkg;

  localparam logic [3:0] ULA_AND  = 4'b0000;
  localparam logic [3:0] ULA_OR   = 4'b0001;
  localparam logic [3:0] ULA_ADD  = 4'b0010;
  localparam logic [3:0] ULA_SUB  = 4'b0110;
  localparam logic [3:0] ULA_SLT  = 4'b0111;
  localparam logic [3:0] ULA_MULT = 4'b1000;
  localparam logic [3:0] ULA_DIV  = 4'b1001;
  localparam logic [3:0] ULA_MFLO = 4'b1010;
  localparam logic [3:0] ULA_MFHI = 4'b1011;
  localparam logic [3:0] ULA_NOR  = 4'b1100;
  localparam logic [3:0] ULA_XOR  = 4'b1101;
  localparam logic [3:0] ULA_LUI  = 4'b1110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    ADJ  = 2'd2
  } md_state_t;

  // True for the opcodes that launch a multi-cycle operation.
  function automatic logic is_md_start(input logic [3:0] op);
    return (op == ULA_MULT) || (op == ULA_DIV);
  endfunction

  // True for the opcodes that read HI/LO.
  function automatic logic is_md_read(input logic [3:0] op);
    return (op == ULA_MFLO) || (op == ULA_MFHI);
  endfunction

endpackage

// File: rtl/ula_muldiv_hilo_if.sv
// Execute-stage connection between the datapath and the multiply/divide unit.
interface ula_muldiv_hilo_if #(parameter int WIDTH = 32);

  logic [3:0]       ULAopcode;
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic             div0;
  logic             stall;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (
    output ULAopcode, start, A, B,
    input  busy, done, div0, stall, result, HI, LO
  );

  modport slave (
    input  ULAopcode, start, A, B,
    output busy, done, div0, stall, result, HI, LO
  );

endinterface

// File: rtl/ula_sign_adjust.sv
// Sign handling around the unsigned iteration core: operand magnitudes in,
// signed product / quotient / remainder out.
module ula_sign_adjust
  import ula_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [WIDTH-1:0]   mag_a,
  output logic [WIDTH-1:0]   mag_b,
  output logic               sign_a,
  output logic               sign_b,
  input  logic               op_sign_a,
  input  logic               op_sign_b,
  input  logic [2*WIDTH-1:0] prod,
  input  logic [WIDTH-1:0]   quot,
  input  logic [WIDTH-1:0]   rem,
  output logic [2*WIDTH-1:0] prod_fix,
  output logic [WIDTH-1:0]   quot_fix,
  output logic [WIDTH-1:0]   rem_fix
);

  // Magnitudes are unsigned, so the most negative operand maps to 2^(WIDTH-1).
  always_comb begin
    sign_a = a[WIDTH-1];
    sign_b = b[WIDTH-1];
    mag_a  = sign_a ? (~a + 1'b1) : a;
    mag_b  = sign_b ? (~b + 1'b1) : b;
  end

  // Product and quotient take the XOR of the signs; remainder follows the dividend.
  always_comb begin
    prod_fix = (op_sign_a ^ op_sign_b) ? (~prod + 1'b1) : prod;
    quot_fix = (op_sign_a ^ op_sign_b) ? (~quot + 1'b1) : quot;
    rem_fix  = op_sign_a ? (~rem + 1'b1) : rem;
  end

endmodule

// File: rtl/ula_muldiv_hilo.sv
// Multi-cycle signed MULT/DIV with architectural HI/LO registers.
//
//   state | meaning
//   IDLE  | waiting for start with MULT/DIV opcode
//   CALC  | WIDTH shift-add or restoring-divide iterations
//   ADJ   | sign correction, HI/LO write, done pulse
module ula_muldiv_hilo
  import ula_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  ula_muldiv_hilo_if.slave bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  md_state_t state_q, state_d;

  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] acc_q;      // MULT: {partial hi, multiplier}; DIV: {remainder, quotient}
  logic [WIDTH-1:0]   opnd_q;     // MULT: |A| addend; DIV: |B| divisor
  logic [WIDTH-1:0]   a_raw_q;
  logic               sign_a_q, sign_b_q, is_div_q, b_zero_q;
  logic               done_q, div0_q;
  logic [WIDTH-1:0]   hi_q, lo_q;

  logic               start_ok;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               sign_a, sign_b;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  logic [WIDTH:0]     mult_sum;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;

  assign start_ok = bus.start && is_md_start(bus.ULAopcode);

  ula_sign_adjust #(.WIDTH(WIDTH)) u_sign_adjust (
    .a         (bus.A),
    .b         (bus.B),
    .mag_a     (mag_a),
    .mag_b     (mag_b),
    .sign_a    (sign_a),
    .sign_b    (sign_b),
    .op_sign_a (sign_a_q),
    .op_sign_b (sign_b_q),
    .prod      (acc_q),
    .quot      (acc_q[WIDTH-1:0]),
    .rem       (acc_q[2*WIDTH-1:WIDTH]),
    .prod_fix  (prod_fix),
    .quot_fix  (quot_fix),
    .rem_fix   (rem_fix)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = CALC;
      CALC:    if (cnt_q == CNT_LAST) state_d = ADJ;
      ADJ:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // One iteration step for each operation; the remainder never exceeds WIDTH bits.
  always_comb begin
    mult_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opnd_q});
    div_rem   = div_ge ? (div_shift[WIDTH-1:0] - opnd_q) : div_shift[WIDTH-1:0];
  end

  // Operand capture, iteration datapath and HI/LO write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      a_raw_q  <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      is_div_q <= 1'b0;
      b_zero_q <= 1'b0;
      done_q   <= 1'b0;
      div0_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      done_q <= 1'b0;
      div0_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_ok) begin
            is_div_q <= (bus.ULAopcode == ULA_DIV);
            sign_a_q <= sign_a;
            sign_b_q <= sign_b;
            a_raw_q  <= bus.A;
            b_zero_q <= (bus.B == '0);
            cnt_q    <= '0;
            if (bus.ULAopcode == ULA_DIV) begin
              opnd_q <= mag_b;
              acc_q  <= {{WIDTH{1'b0}}, mag_a};
            end else begin
              opnd_q <= mag_a;
              acc_q  <= {{WIDTH{1'b0}}, mag_b};
            end
          end
        end
        CALC: begin
          cnt_q <= cnt_q + 1'b1;
          if (is_div_q) acc_q <= {div_rem, acc_q[WIDTH-2:0], div_ge};
          else          acc_q <= {mult_sum, acc_q[WIDTH-1:1]};
        end
        ADJ: begin
          done_q <= 1'b1;
          div0_q <= is_div_q && b_zero_q;
          if (!is_div_q) begin
            {hi_q, lo_q} <= prod_fix;
          end else if (b_zero_q) begin
            hi_q <= a_raw_q;
            lo_q <= '1;
          end else begin
            hi_q <= rem_fix;
            lo_q <= quot_fix;
          end
        end
        default: ;
      endcase
    end
  end

  // MFLO/MFHI read path and handshake outputs.
  always_comb begin
    case (bus.ULAopcode)
      ULA_MFLO: bus.result = lo_q;
      ULA_MFHI: bus.result = hi_q;
      default:  bus.result = '0;
    endcase
    bus.busy  = (state_q != IDLE);
    bus.stall = (state_q != IDLE) && is_md_read(bus.ULAopcode);
    bus.done  = done_q;
    bus.div0  = div0_q;
    bus.HI    = hi_q;
    bus.LO    = lo_q;
  end

endmodule

// File: tb/tb_ula_muldiv_hilo.sv
// Self-checking bench for ula_muldiv_hilo against a plain-arithmetic model.
module tb_ula_muldiv_hilo;
  import ula_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ula_muldiv_hilo_if #(.WIDTH(W)) bus ();

  ula_muldiv_hilo #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  // Reference: signed arithmetic straight from the operation definitions.
  task automatic model_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] hi, output logic [31:0] lo, output logic dz);
    longint p;
    int sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    dz = 1'b0;
    if (op == ULA_MULT) begin
      p  = longint'(sa) * longint'(sb);
      hi = p[63:32];
      lo = p[31:0];
    end else if (b == 32'd0) begin
      dz = 1'b1;
      hi = a;
      lo = 32'hFFFF_FFFF;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      hi = 32'd0;
      lo = 32'h8000_0000;
    end else begin
      lo = sa / sb;
      hi = sa % sb;
    end
  endtask

  function automatic logic [W-1:0] read_val(input logic [3:0] op, input logic [W-1:0] hi,
                                            input logic [W-1:0] lo);
    if (op == ULA_MFLO) return lo;
    if (op == ULA_MFHI) return hi;
    return '0;
  endfunction

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd1;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Launches one operation on the next edge and follows it to the done cycle.
  // Returns #1 after the done edge, so another start may be issued at once.
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [3:0] idle_op, input string tag);
    logic [W-1:0] eh, el, old_res, new_res;
    logic ez, mf;
    model_op(op, a, b, eh, el, ez);
    mf = (idle_op == ULA_MFLO) || (idle_op == ULA_MFHI);
    bus.ULAopcode = op;
    bus.start = 1'b1;
    bus.A = a;
    bus.B = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.ULAopcode = idle_op;
    bus.A = $urandom;
    bus.B = $urandom;
    #1;
    old_res = read_val(idle_op, m_hi, m_lo);
    for (int e = 0; e <= W; e++) begin
      if (e > 0) begin @(posedge clk); #1; end
      checks++;
      if (bus.busy !== 1'b1) begin errors++; $display("FAIL %s busy e=%0d got=%b exp=1", tag, e, bus.busy); end
      checks++;
      if (bus.done !== 1'b0) begin errors++; $display("FAIL %s early_done e=%0d got=%b exp=0", tag, e, bus.done); end
      checks++;
      if (bus.stall !== mf) begin errors++; $display("FAIL %s stall e=%0d got=%b exp=%b", tag, e, bus.stall, mf); end
      checks++;
      if (bus.result !== old_res) begin errors++; $display("FAIL %s old_result e=%0d got=%h exp=%h", tag, e, bus.result, old_res); end
    end
    @(posedge clk); #1;
    m_hi = eh;
    m_lo = el;
    new_res = read_val(idle_op, eh, el);
    checks++;
    if (bus.done !== 1'b1) begin errors++; $display("FAIL %s done got=%b exp=1", tag, bus.done); end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL %s busy_end got=%b exp=0", tag, bus.busy); end
    checks++;
    if (bus.div0 !== ez) begin errors++; $display("FAIL %s div0 got=%b exp=%b", tag, bus.div0, ez); end
    checks++;
    if (bus.HI !== eh) begin errors++; $display("FAIL %s HI a=%h b=%h got=%h exp=%h", tag, a, b, bus.HI, eh); end
    checks++;
    if (bus.LO !== el) begin errors++; $display("FAIL %s LO a=%h b=%h got=%h exp=%h", tag, a, b, bus.LO, el); end
    checks++;
    if (bus.stall !== 1'b0) begin errors++; $display("FAIL %s stall_done got=%b exp=0", tag, bus.stall); end
    checks++;
    if (bus.result !== new_res) begin errors++; $display("FAIL %s new_result got=%h exp=%h", tag, bus.result, new_res); end
  endtask

  task automatic test_reset();
    bus.ULAopcode = ULA_MFLO;
    bus.start = 1'b0;
    bus.A = '0;
    bus.B = '0;
    #3;
    checks++;
    if (bus.HI !== '0) begin errors++; $display("FAIL reset_hi got=%h exp=0", bus.HI); end
    checks++;
    if (bus.LO !== '0) begin errors++; $display("FAIL reset_lo got=%h exp=0", bus.LO); end
    checks++;
    if ({bus.busy, bus.done, bus.div0, bus.stall} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got=%b exp=0000", {bus.busy, bus.done, bus.div0, bus.stall});
    end
    checks++;
    if (bus.result !== '0) begin errors++; $display("FAIL reset_result got=%h exp=0", bus.result); end
    @(negedge clk);
    rst_n = 1'b1;
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
  endtask

  task automatic test_mult();
    run_op(ULA_MULT, 32'd7, 32'hFFFF_FFFD, ULA_ADD, "mult_7x-3");
    @(posedge clk); #1;
    checks++;
    if (bus.done !== 1'b0) begin errors++; $display("FAIL mult_done_width got=%b exp=0", bus.done); end
    run_op(ULA_MULT, 32'h8000_0000, 32'h8000_0000, ULA_AND, "mult_min_min");
    @(posedge clk); #1;
    bus.ULAopcode = ULA_MFHI;
    #1;
    checks++;
    if (bus.result !== 32'h4000_0000) begin errors++; $display("FAIL mfhi_result got=%h exp=40000000", bus.result); end
    checks++;
    if (bus.stall !== 1'b0) begin errors++; $display("FAIL mfhi_stall got=%b exp=0", bus.stall); end
  endtask

  task automatic test_div();
    run_op(ULA_DIV, 32'hFFFF_FFF9, 32'd2, ULA_MFLO, "div_-7/2");
    run_op(ULA_DIV, 32'h8000_0000, 32'hFFFF_FFFF, ULA_MFHI, "div_min/-1");
  endtask

  task automatic test_div0();
    run_op(ULA_DIV, 32'h1234_5678, 32'd0, ULA_MFHI, "div0");
    @(posedge clk); #1;
    checks++;
    if (bus.div0 !== 1'b0) begin errors++; $display("FAIL div0_width got=%b exp=0", bus.div0); end
  endtask

  task automatic test_stall_ignore();
    logic [W-1:0] eh, el, old_lo;
    logic ez;
    int done_cnt, done_edge;
    model_op(ULA_MULT, 32'h1234, 32'h10, eh, el, ez);
    old_lo = m_lo;
    done_cnt = 0;
    done_edge = -1;
    bus.ULAopcode = ULA_MULT;
    bus.start = 1'b1;
    bus.A = 32'h1234;
    bus.B = 32'h10;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.ULAopcode = ULA_ADD;
    for (int e = 1; e <= W + 41; e++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) begin done_cnt++; done_edge = e; end
      if (e == 5) begin
        bus.ULAopcode = ULA_MFLO;
        #1;
        checks++;
        if (bus.stall !== 1'b1) begin errors++; $display("FAIL busy_mflo_stall got=%b exp=1", bus.stall); end
        checks++;
        if (bus.result !== old_lo) begin errors++; $display("FAIL busy_mflo_result got=%h exp=%h", bus.result, old_lo); end
      end
      if (e == 10) begin
        bus.ULAopcode = ULA_MULT;
        bus.start = 1'b1;
        bus.A = 32'h5555;
        bus.B = 32'h3;
      end
      if (e == 11) begin
        bus.start = 1'b0;
        bus.ULAopcode = ULA_MFLO;
      end
      if (e == W + 1) begin
        checks++;
        if (bus.result !== el) begin errors++; $display("FAIL done_cycle_result got=%h exp=%h", bus.result, el); end
      end
    end
    m_hi = eh;
    m_lo = el;
    checks++;
    if (done_cnt !== 1) begin errors++; $display("FAIL ignored_start_done_count got=%0d exp=1", done_cnt); end
    checks++;
    if (done_edge !== W + 1) begin errors++; $display("FAIL ignored_start_done_edge got=%0d exp=%0d", done_edge, W + 1); end
    checks++;
    if ({bus.HI, bus.LO} !== {eh, el}) begin
      errors++; $display("FAIL ignored_start_hilo got=%h_%h exp=%h_%h", bus.HI, bus.LO, eh, el);
    end
  endtask

  task automatic test_reset_mid();
    int done_cnt;
    done_cnt = 0;
    bus.ULAopcode = ULA_DIV;
    bus.start = 1'b1;
    bus.A = 32'h0BAD_F00D;
    bus.B = 32'd37;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.ULAopcode = ULA_ADD;
    for (int e = 1; e <= 20; e++) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.HI, bus.LO} !== '0) begin errors++; $display("FAIL midreset_hilo got=%h_%h exp=0", bus.HI, bus.LO); end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got=%b exp=0", bus.busy); end
    @(negedge clk);
    rst_n = 1'b1;
    m_hi = '0;
    m_lo = '0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (bus.done !== 1'b0) done_cnt++;
    end
    checks++;
    if (done_cnt !== 0) begin errors++; $display("FAIL midreset_no_done got=%0d exp=0", done_cnt); end
    run_op(ULA_MULT, 32'd3, 32'd4, ULA_MFLO, "mult_3x4_after_reset");
  endtask

  task automatic test_back_to_back();
    run_op(ULA_MULT, 32'hFFFF_0001, 32'h0001_FFFF, ULA_MFHI, "b2b_0");
    run_op(ULA_DIV, 32'd100, 32'hFFFF_FFF9, ULA_MFLO, "b2b_1");
    run_op(ULA_DIV, 32'hFFFF_FF9C, 32'd7, ULA_MFHI, "b2b_2");
  endtask

  task automatic test_random();
    logic [3:0] op, idle;
    for (int i = 0; i < 16; i++) begin
      op = ($urandom_range(0, 1) == 0) ? ULA_MULT : ULA_DIV;
      idle = 4'($urandom_range(0, 15));
      run_op(op, pick_operand(), pick_operand(), idle, "random");
      bus.ULAopcode = ULA_ADD;
      for (int g = $urandom_range(0, 2); g > 0; g--) begin @(posedge clk); #1; end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div0();
    test_stall_ignore();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
